reg_csr_file: RTL and testbench
===============================

Name: reg_csr_file

Overview:
- Parametrised successor to the decode-to-exec CSR read stage.
- Holds real CSR storage: a window of DEPTH generic read/write CSRs, plus 64-bit mcycle and minstret counters with read-only cycle/instret shadows.
- Supports a configurable number of forwarding channels with full-width address compare, and a writeback port.
- Sits between decode and exec. The captured read address is presented one cycle after decode.

Parameters:
- DATA_W, 32, CSR data width (must be 32; counters split into low/high words)
- ADDR_W, 12, CSR address width; all compares use the full width
- DEPTH, 16, number of generic R/W CSR slots (power of 2, 1..64)
- BASE_ADDR, 12'h300, address of generic slot 0; slot k maps to BASE_ADDR+k
- FWD_CH, 2, number of forwarding channels; channel 0 has highest priority

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- FLUSH  in  1  pipeline flush, clears captured inputs
- STALL  in  1  pipeline stall
- MEM_WAIT  in  1  memory wait, freezes captured inputs
- RIADDR  in  ADDR_W  read address from decode
- RVALID  out  1  RDATA is usable (no unresolved hazard)
- ROADDR  out  ADDR_W  captured read address
- RDATA  out  DATA_W  read data
- WREN  in  1  writeback commit
- WADDR  in  ADDR_W  writeback address
- WDATA  in  DATA_W  writeback data
- INSTRET  in  1  one instruction retired this cycle
- FWD_CSR_EN  in  1  decode holds a CSR-writing instruction
- FWD_CSR_ADDR  in  ADDR_W  its target address
- FWD_EN  in  FWD_CH  channel i carries a CSR write
- FWD_RDY  in  FWD_CH  channel i data valid
- FWD_ADDR  in  FWD_CH*ADDR_W  channel i address, at slice i
- FWD_DATA  in  FWD_CH*DATA_W  channel i data, at slice i

Behaviour:
- Capture register priority: RST|FLUSH > STALL > MEM_WAIT > normal.
  - RST|FLUSH: clear riaddr, pending CSR enable/addr and all captured FWD_* to 0.
  - STALL: hold riaddr; clear pending CSR enable; load all FWD_*.
  - MEM_WAIT: hold everything.
  - Normal: load RIADDR, FWD_CSR_*, FWD_*.
- Address map:
  - Generic slots: BASE_ADDR..BASE_ADDR+DEPTH-1.
  - mcycle = 0xB00, mcycleh = 0xB80.
  - minstret = 0xB02, minstreth = 0xB82.
  - cycle/cycleh = 0xC00/0xC80 and instret/instreth = 0xC02/0xC82 are read-only mirrors.
  - All other addresses read 0; writes to them are ignored.
- Writeback:
  - WREN commits at the clock edge regardless of STALL/FLUSH/MEM_WAIT; it is ignored while RST is high.
  - Writes to read-only mirrors are ignored.
- Counters (64-bit, wrap from all-ones to 0):
  - mcycle increments every non-reset cycle.
  - minstret increments when INSTRET=1.
  - A write to either half replaces that half. That cycle's increment is suppressed for the whole counter (write wins, no carry into the other half).
- RDATA (combinational from the captured riaddr), first match wins:
  1. Lowest-index channel i with fwd_en[i] and fwd_addr[i]==riaddr → fwd_data[i].
  2. WREN and WADDR==riaddr on a mapped writable address → WDATA (same-cycle bypass).
  3. Otherwise the storage/counter value, or 0 if unmapped.
- RVALID=0 in either case:
  - Captured pending-CSR enable is 1 and its address == riaddr.
  - The highest-priority matching enabled channel has fwd_rdy=0.
- RVALID=1 otherwise.
- ROADDR = riaddr.
- Reset values:
  - riaddr=0, so ROADDR=0, RDATA=0, RVALID=1.
  - All slots 0; both counters 0 (mcycle reads 0 only in the first post-reset cycle).
- Reset mid-operation discards captured state. A WREN in a reset cycle is lost.

Test Plan:
- Reset, then WREN WADDR=0x301 WDATA=0xDEADBEEF; next cycle RIADDR=0x301 → one cycle later RDATA=0xDEADBEEF, RVALID=1, ROADDR=0x301.
- Captured riaddr=0x305; FWD_EN=2'b11, both ADDR=0x305, DATA0=0x11, DATA1=0x22, RDY=2'b11 → RDATA=0x11. Then FWD_EN=2'b10 → RDATA=0x22. Then RDY[1]=0 → RVALID=0.
- Captured address 0x0305 with channel address 0x0105, or any other address differing only above bit 4 → no forward; RDATA = slot value.
- FWD_CSR_EN=1, FWD_CSR_ADDR=0x300, RIADDR=0x300 → RVALID=0 next cycle. STALL=1 for one cycle → riaddr held at 0x300, RVALID=1.
- Write mcycle=0xFFFFFFFF and mcycleh=0 on consecutive cycles → within 2 cycles mcycleh reads 1. Write minstret with INSTRET=1 same cycle → the written value persists (no +1). A write to 0xC00 has no effect.
- MEM_WAIT=1 while RIADDR changes → ROADDR unchanged. FLUSH=1 → ROADDR=0, RDATA=0, RVALID=1.

Source files
------------

// File: rtl/reg_csr_file.sv
// CSR read stage with real storage: generic R/W slots, 64-bit mcycle/minstret with
// read-only user mirrors, multi-channel forwarding and a same-cycle writeback bypass.
module reg_csr_file #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 12,
  parameter int                 DEPTH     = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 12'h300,
  parameter int                 FWD_CH    = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FLUSH,
  input  logic                       STALL,
  input  logic                       MEM_WAIT,
  input  logic [ADDR_W-1:0]          RIADDR,
  output logic                       RVALID,
  output logic [ADDR_W-1:0]          ROADDR,
  output logic [DATA_W-1:0]          RDATA,
  input  logic                       WREN,
  input  logic [ADDR_W-1:0]          WADDR,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic                       INSTRET,
  input  logic                       FWD_CSR_EN,
  input  logic [ADDR_W-1:0]          FWD_CSR_ADDR,
  input  logic [FWD_CH-1:0]          FWD_EN,
  input  logic [FWD_CH-1:0]          FWD_RDY,
  input  logic [FWD_CH*ADDR_W-1:0]   FWD_ADDR,
  input  logic [FWD_CH*DATA_W-1:0]   FWD_DATA
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] A_MCYCLE    = ADDR_W'(12'hB00);
  localparam logic [ADDR_W-1:0] A_MCYCLEH   = ADDR_W'(12'hB80);
  localparam logic [ADDR_W-1:0] A_MINSTRET  = ADDR_W'(12'hB02);
  localparam logic [ADDR_W-1:0] A_MINSTRETH = ADDR_W'(12'hB82);
  localparam logic [ADDR_W-1:0] A_CYCLE     = ADDR_W'(12'hC00);
  localparam logic [ADDR_W-1:0] A_CYCLEH    = ADDR_W'(12'hC80);
  localparam logic [ADDR_W-1:0] A_INSTRET   = ADDR_W'(12'hC02);
  localparam logic [ADDR_W-1:0] A_INSTRETH  = ADDR_W'(12'hC82);

  // ---------------- capture registers ----------------
  logic [ADDR_W-1:0]         riaddr_q, riaddr_d;
  logic                      csr_en_q, csr_en_d;
  logic [ADDR_W-1:0]         csr_addr_q, csr_addr_d;
  logic [FWD_CH-1:0]         fwd_en_q, fwd_en_d;
  logic [FWD_CH-1:0]         fwd_rdy_q, fwd_rdy_d;
  logic [FWD_CH*ADDR_W-1:0]  fwd_addr_q, fwd_addr_d;
  logic [FWD_CH*DATA_W-1:0]  fwd_data_q, fwd_data_d;

  always_comb begin
    riaddr_d   = riaddr_q;
    csr_en_d   = csr_en_q;
    csr_addr_d = csr_addr_q;
    fwd_en_d   = fwd_en_q;
    fwd_rdy_d  = fwd_rdy_q;
    fwd_addr_d = fwd_addr_q;
    fwd_data_d = fwd_data_q;
    if (FLUSH) begin
      riaddr_d   = '0;
      csr_en_d   = 1'b0;
      csr_addr_d = '0;
      fwd_en_d   = '0;
      fwd_rdy_d  = '0;
      fwd_addr_d = '0;
      fwd_data_d = '0;
    end else if (STALL) begin
      // the stalled instruction stays in place, so its own pending write no longer blocks it
      csr_en_d   = 1'b0;
      fwd_en_d   = FWD_EN;
      fwd_rdy_d  = FWD_RDY;
      fwd_addr_d = FWD_ADDR;
      fwd_data_d = FWD_DATA;
    end else if (!MEM_WAIT) begin
      riaddr_d   = RIADDR;
      csr_en_d   = FWD_CSR_EN;
      csr_addr_d = FWD_CSR_ADDR;
      fwd_en_d   = FWD_EN;
      fwd_rdy_d  = FWD_RDY;
      fwd_addr_d = FWD_ADDR;
      fwd_data_d = FWD_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      riaddr_q   <= '0;
      csr_en_q   <= 1'b0;
      csr_addr_q <= '0;
      fwd_en_q   <= '0;
      fwd_rdy_q  <= '0;
      fwd_addr_q <= '0;
      fwd_data_q <= '0;
    end else begin
      riaddr_q   <= riaddr_d;
      csr_en_q   <= csr_en_d;
      csr_addr_q <= csr_addr_d;
      fwd_en_q   <= fwd_en_d;
      fwd_rdy_q  <= fwd_rdy_d;
      fwd_addr_q <= fwd_addr_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // ---------------- writeback decode ----------------
  logic              wr_ok;
  logic [ADDR_W-1:0] w_off;
  logic              w_slot;
  logic              w_mapped;

  assign wr_ok  = WREN & ~RST;
  assign w_off  = WADDR - BASE_ADDR;
  assign w_slot = (w_off < ADDR_W'(DEPTH));
  assign w_mapped = w_slot || (WADDR == A_MCYCLE) || (WADDR == A_MCYCLEH) ||
                    (WADDR == A_MINSTRET) || (WADDR == A_MINSTRETH);

  // ---------------- generic slots ----------------
  logic [DATA_W-1:0] slot_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
    end else if (wr_ok && w_slot) begin
      slot_q[w_off[IDX_W-1:0]] <= WDATA;
    end
  end

  // ---------------- counters ----------------
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  // a write to either half replaces it and suppresses that cycle's increment entirely
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (wr_ok && WADDR == A_MCYCLE)       mcycle_d = {mcycle_q[63:32], WDATA};
    else if (wr_ok && WADDR == A_MCYCLEH) mcycle_d = {WDATA, mcycle_q[31:0]};

    minstret_d = INSTRET ? (minstret_q + 64'd1) : minstret_q;
    if (wr_ok && WADDR == A_MINSTRET)       minstret_d = {minstret_q[63:32], WDATA};
    else if (wr_ok && WADDR == A_MINSTRETH) minstret_d = {WDATA, minstret_q[31:0]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // ---------------- read path ----------------
  logic [ADDR_W-1:0] r_off;
  logic              r_slot;
  logic [DATA_W-1:0] store_rd;

  assign r_off  = riaddr_q - BASE_ADDR;
  assign r_slot = (r_off < ADDR_W'(DEPTH));

  always_comb begin
    store_rd = '0;
    if (r_slot) store_rd = slot_q[r_off[IDX_W-1:0]];
    else begin
      case (riaddr_q)
        A_MCYCLE,   A_CYCLE:    store_rd = mcycle_q[31:0];
        A_MCYCLEH,  A_CYCLEH:   store_rd = mcycle_q[63:32];
        A_MINSTRET, A_INSTRET:  store_rd = minstret_q[31:0];
        A_MINSTRETH, A_INSTRETH: store_rd = minstret_q[63:32];
        default:                store_rd = '0;
      endcase
    end
  end

  logic              fwd_hit;
  logic              fwd_sel_rdy;
  logic [DATA_W-1:0] fwd_sel_data;

  always_comb begin
    fwd_hit      = 1'b0;
    fwd_sel_rdy  = 1'b1;
    fwd_sel_data = '0;
    for (int i = 0; i < FWD_CH; i++) begin
      if (!fwd_hit && fwd_en_q[i] && (fwd_addr_q[i*ADDR_W +: ADDR_W] == riaddr_q)) begin
        fwd_hit      = 1'b1;
        fwd_sel_rdy  = fwd_rdy_q[i];
        fwd_sel_data = fwd_data_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    if (fwd_hit)                                        RDATA = fwd_sel_data;
    else if (wr_ok && w_mapped && (WADDR == riaddr_q))  RDATA = WDATA;
    else                                                RDATA = store_rd;
  end

  assign RVALID = ~(csr_en_q && (csr_addr_q == riaddr_q)) & ~(fwd_hit && !fwd_sel_rdy);
  assign ROADDR = riaddr_q;

endmodule

// File: tb/tb_reg_csr_file.sv
// Directed bench for reg_csr_file: capture priority, storage, counters, forwarding, bypass.
module tb_reg_csr_file;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, STALL, MEM_WAIT;
  logic [11:0] RIADDR;
  logic        RVALID;
  logic [11:0] ROADDR;
  logic [31:0] RDATA;
  logic        WREN;
  logic [11:0] WADDR;
  logic [31:0] WDATA;
  logic        INSTRET;
  logic        FWD_CSR_EN;
  logic [11:0] FWD_CSR_ADDR;
  logic [1:0]  FWD_EN, FWD_RDY;
  logic [23:0] FWD_ADDR;
  logic [63:0] FWD_DATA;

  int total = 0;
  int bad   = 0;

  reg_csr_file dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(STALL), .MEM_WAIT(MEM_WAIT),
    .RIADDR(RIADDR), .RVALID(RVALID), .ROADDR(ROADDR), .RDATA(RDATA),
    .WREN(WREN), .WADDR(WADDR), .WDATA(WDATA), .INSTRET(INSTRET),
    .FWD_CSR_EN(FWD_CSR_EN), .FWD_CSR_ADDR(FWD_CSR_ADDR),
    .FWD_EN(FWD_EN), .FWD_RDY(FWD_RDY), .FWD_ADDR(FWD_ADDR), .FWD_DATA(FWD_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    WREN = 1'b1; WADDR = a; WDATA = d;
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0; STALL = 1'b0; MEM_WAIT = 1'b0;
    RIADDR = 12'h0; WREN = 1'b0; WADDR = 12'h0; WDATA = 32'h0; INSTRET = 1'b0;
    FWD_CSR_EN = 1'b0; FWD_CSR_ADDR = 12'h0; FWD_EN = 2'b00; FWD_RDY = 2'b00;
    FWD_ADDR = 24'h0; FWD_DATA = 64'h0;
    tick(); tick();
    check("rst_roaddr", {20'h0, ROADDR}, 32'h0);
    check("rst_rdata",  RDATA, 32'h0);
    check("rst_rvalid", {31'h0, RVALID}, 32'h1);

    // first non-reset edge takes mcycle 0 -> 1
    RST = 1'b0; RIADDR = 12'hB00;
    tick();
    check("mcycle_first", RDATA, 32'h1);
    tick();
    check("mcycle_second", RDATA, 32'h2);

    // basic write then read
    RIADDR = 12'h0; wr(12'h301, 32'hDEADBEEF);
    tick();
    WREN = 1'b0; RIADDR = 12'h301;
    tick();
    check("wr_rd_data",   RDATA, 32'hDEADBEEF);
    check("wr_rd_valid",  {31'h0, RVALID}, 32'h1);
    check("wr_rd_roaddr", {20'h0, ROADDR}, 32'h301);

    // same-cycle writeback bypass
    RIADDR = 12'h302;
    tick();
    check("slot302_empty", RDATA, 32'h0);
    wr(12'h302, 32'h12345678);
    #1 check("bypass", RDATA, 32'h12345678);
    tick();
    WREN = 1'b0;
    #1 check("bypass_stored", RDATA, 32'h12345678);

    // top slot and first unmapped address past the window
    wr(12'h30F, 32'h0000F0F0);
    tick();
    wr(12'h310, 32'hAAAA5555); RIADDR = 12'h30F;
    tick();
    WREN = 1'b0; RIADDR = 12'h310;
    check("slot_top", RDATA, 32'h0000F0F0);
    tick();
    check("unmapped_rd", RDATA, 32'h0);

    // forwarding priority
    wr(12'h305, 32'h55);
    tick();
    WREN = 1'b0; RIADDR = 12'h305;
    FWD_EN = 2'b11; FWD_RDY = 2'b11;
    FWD_ADDR = {12'h305, 12'h305}; FWD_DATA = {32'h22, 32'h11};
    tick();
    check("fwd_ch0", RDATA, 32'h11);
    check("fwd_ch0_valid", {31'h0, RVALID}, 32'h1);
    FWD_EN = 2'b10;
    tick();
    check("fwd_ch1", RDATA, 32'h22);
    FWD_RDY = 2'b01;
    tick();
    check("fwd_ch1_notrdy", {31'h0, RVALID}, 32'h0);
    FWD_EN = 2'b01; FWD_RDY = 2'b01; FWD_ADDR = {12'h305, 12'h105};
    tick();
    check("fwd_fullcmp_data",  RDATA, 32'h55);
    check("fwd_fullcmp_valid", {31'h0, RVALID}, 32'h1);
    FWD_EN = 2'b00; FWD_RDY = 2'b00;

    // pending CSR write hazard, cleared by stall
    FWD_CSR_EN = 1'b1; FWD_CSR_ADDR = 12'h300; RIADDR = 12'h300;
    tick();
    check("hazard_valid", {31'h0, RVALID}, 32'h0);
    STALL = 1'b1; RIADDR = 12'h301;
    tick();
    check("stall_roaddr", {20'h0, ROADDR}, 32'h300);
    check("stall_valid",  {31'h0, RVALID}, 32'h1);
    STALL = 1'b0; FWD_CSR_EN = 1'b0;

    // mcycle carry from low into high after writes
    wr(12'hB00, 32'hFFFFFFFF);
    tick();
    wr(12'hB80, 32'h0); RIADDR = 12'hB80;
    tick();
    WREN = 1'b0;
    #1 check("mcycleh_written", RDATA, 32'h0);
    tick();
    check("mcycleh_carry", RDATA, 32'h1);
    RIADDR = 12'hC00;
    tick();
    check("cycle_mirror_lo", RDATA, 32'h1);

    // mirror writes ignored, no bypass
    RIADDR = 12'hC80;
    tick();
    wr(12'hC80, 32'h77);
    #1 check("mirror_nobypass", RDATA, 32'h1);
    tick();
    WREN = 1'b0;
    #1 check("mirror_nowrite", RDATA, 32'h1);

    // minstret write beats increment
    wr(12'hB02, 32'h100); INSTRET = 1'b1;
    tick();
    WREN = 1'b0; INSTRET = 1'b0; RIADDR = 12'hB02;
    tick();
    check("minstret_wr_wins", RDATA, 32'h100);
    INSTRET = 1'b1;
    tick();
    INSTRET = 1'b0;
    check("minstret_inc", RDATA, 32'h101);
    wr(12'hC02, 32'hABC);
    #1 check("instret_mirror_nobypass", RDATA, 32'h101);
    tick();
    WREN = 1'b0;
    #1 check("instret_mirror_nowrite", RDATA, 32'h101);

    // MEM_WAIT freeze then FLUSH
    RIADDR = 12'h301;
    tick();
    MEM_WAIT = 1'b1; RIADDR = 12'h305;
    tick();
    check("memwait_roaddr", {20'h0, ROADDR}, 32'h301);
    check("memwait_rdata",  RDATA, 32'hDEADBEEF);
    MEM_WAIT = 1'b0; FLUSH = 1'b1;
    tick();
    check("flush_roaddr", {20'h0, ROADDR}, 32'h0);
    check("flush_rdata",  RDATA, 32'h0);
    check("flush_rvalid", {31'h0, RVALID}, 32'h1);
    FLUSH = 1'b0;

    // reset mid-operation loses storage and the write in the reset cycle
    RIADDR = 12'h301;
    tick();
    RST = 1'b1; wr(12'h302, 32'h999);
    tick();
    check("rst_mid_roaddr", {20'h0, ROADDR}, 32'h0);
    RST = 1'b0; WREN = 1'b0;
    tick();
    check("rst_mid_slot301", RDATA, 32'h0);
    RIADDR = 12'h302;
    tick();
    check("rst_mid_lostwr", RDATA, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
